// File: rtl/pc_gen.sv
// Program-counter stage: holds the architectural PC, sequences fetch/execute and counts retirements.
// Optional misaligned-target halt is enabled by defining PC_MISALIGN_CHECK_EN.
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCAsrc,
    input  logic             PCBsrc,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    input  logic             is_jalr,
    output logic             if_req_valid,
    input  logic             if_req_ready,
    output logic [31:0]      if_req_addr,
    input  logic             inst_valid,
    input  logic             commit_valid,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             pc_misalign,
    output logic             halted
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic              r_if_req_valid;
    logic              w_commit;
    logic [XLEN-1:0]   w_op_a;
    logic [XLEN-1:0]   w_op_b;
    logic [XLEN-1:0]   w_sum;
    logic [XLEN-1:0]   w_next_pc;

    // Next-PC adder; carry out is dropped, JALR clears bit 0.
    assign w_op_a    = PCAsrc ? imm : XLEN'(4);
    assign w_op_b    = PCBsrc ? rs1_data : r_pc;
    assign w_sum     = w_op_a + w_op_b;
    assign w_next_pc = {w_sum[XLEN-1:1], w_sum[0] & ~is_jalr};

`ifdef PC_MISALIGN_CHECK_EN
    logic r_pc_misalign;
    logic r_halted;
    logic w_misalign;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
        w_misalign  = 1'b0;
`endif
        case (r_state)
            S_REQ:  if (if_req_ready) w_state_nxt = S_WAIT;
            S_WAIT: if (inst_valid)   w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (commit_valid) begin
`ifdef PC_MISALIGN_CHECK_EN
                    if (w_next_pc[1:0] != 2'b00) begin
                        w_misalign  = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_REQ;
                    end
`else
                    w_commit    = 1'b1;
                    w_state_nxt = S_REQ;
`endif
                end
            end
            S_HALT: w_state_nxt = S_HALT;
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_REQ;
            r_pc           <= RESET_PC;
            r_retire_cnt   <= '0;
            r_if_req_valid <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_if_req_valid <= (w_state_nxt == S_REQ);
            if (w_commit) begin
                r_pc         <= w_next_pc;
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    // Sticky misalign flag and halt indicator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_misalign <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_pc_misalign <= r_pc_misalign | w_misalign;
            r_halted      <= (w_state_nxt == S_HALT);
        end
    end

    assign pc_misalign = r_pc_misalign;
    assign halted      = r_halted;
`else
    assign pc_misalign = 1'b0;
    assign halted      = 1'b0;
`endif

    assign if_req_valid = r_if_req_valid;
    assign if_req_addr  = r_pc;
    assign pc           = r_pc;
    assign retire_cnt   = r_retire_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (both PC_MISALIGN_CHECK_EN builds).
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        PCAsrc;
    logic        PCBsrc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        is_jalr;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        inst_valid;
    logic        commit_valid;
    logic [31:0] pc;
    logic [63:0] retire_cnt;
    logic        pc_misalign;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .PCAsrc       (PCAsrc),
        .PCBsrc       (PCBsrc),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .is_jalr      (is_jalr),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .inst_valid   (inst_valid),
        .commit_valid (commit_valid),
        .pc           (pc),
        .retire_cnt   (retire_cnt),
        .pc_misalign  (pc_misalign),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full REQ -> WAIT -> EXEC -> commit sequence with the given operands.
    task automatic run_instr(input logic a, input logic b, input logic [31:0] im,
                             input logic [31:0] r1, input logic jr);
        if_req_ready = 1'b1;
        step();
        if_req_ready = 1'b0;
        check("wait_valid_low", 64'(if_req_valid), 64'd0);
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        check("exec_valid_low", 64'(if_req_valid), 64'd0);
        PCAsrc = a; PCBsrc = b; imm = im; rs1_data = r1; is_jalr = jr;
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
        PCAsrc = 1'b0; PCBsrc = 1'b0; imm = '0; rs1_data = '0; is_jalr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; PCAsrc = 1'b0; PCBsrc = 1'b0; imm = '0; rs1_data = '0;
        is_jalr = 1'b0; if_req_ready = 1'b0; inst_valid = 1'b0; commit_valid = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_valid", 64'(if_req_valid), 64'd1);
        check("rst_addr", 64'(if_req_addr), 64'h8000_0000);
        check("rst_cnt", retire_cnt, 64'd0);
        check("rst_misalign", 64'(pc_misalign), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);

        // Sequential fetch, 3-cycle period.
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("seq1_valid", 64'(if_req_valid), 64'd1);
        check("seq1_addr", 64'(if_req_addr), 64'h8000_0004);
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("seq2_addr", 64'(if_req_addr), 64'h8000_0008);
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("seq3_pc", 64'(pc), 64'h8000_000C);
        check("seq3_cnt", retire_cnt, 64'd3);

        // Taken branch backwards from 80000010.
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("pre_br_pc", 64'(pc), 64'h8000_0010);
        run_instr(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0);
        check("branch_pc", 64'(pc), 64'h8000_0000);
        check("branch_cnt", retire_cnt, 64'd5);

        // Backpressure with stray pulses.
        for (int i = 0; i < 5; i++) begin
            commit_valid = 1'b1;
            inst_valid   = (i == 2);
            step();
            check("bp_valid", 64'(if_req_valid), 64'd1);
            check("bp_addr", 64'(if_req_addr), 64'h8000_0000);
            check("bp_cnt", retire_cnt, 64'd5);
        end
        commit_valid = 1'b0;
        inst_valid   = 1'b0;

        // JALR with odd target.
        run_instr(1'b1, 1'b1, 32'h2, 32'h8000_0101, 1'b1);
`ifdef PC_MISALIGN_CHECK_EN
        check("jalr_pc_hold", 64'(pc), 64'h8000_0000);
        check("jalr_cnt_hold", retire_cnt, 64'd5);
        check("jalr_misalign", 64'(pc_misalign), 64'd1);
        check("jalr_halted", 64'(halted), 64'd1);
        if_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_valid = 1'b1; commit_valid = 1'b1;
            step();
            check("halt_valid_low", 64'(if_req_valid), 64'd0);
        end
        if_req_ready = 1'b0; inst_valid = 1'b0; commit_valid = 1'b0;
`else
        check("jalr_pc", 64'(pc), 64'h8000_0102);
        check("jalr_cnt", retire_cnt, 64'd6);
        check("jalr_misalign", 64'(pc_misalign), 64'd0);
        check("jalr_halted", 64'(halted), 64'd0);
`endif

        // Reset in EXEC together with commit_valid; reset wins.
        rst = 1'b0;
        if_req_ready = 1'b1;
        step();
        if_req_ready = 1'b0;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        commit_valid = 1'b1;
        PCAsrc = 1'b1; imm = 32'h0000_0100;
        rst = 1'b1;
        step();
        rst = 1'b0; commit_valid = 1'b0; PCAsrc = 1'b0; imm = '0;
        check("midrst_pc", 64'(pc), 64'h8000_0000);
        check("midrst_cnt", retire_cnt, 64'd0);
        check("midrst_valid", 64'(if_req_valid), 64'd1);
        check("midrst_misalign", 64'(pc_misalign), 64'd0);
        check("midrst_halted", 64'(halted), 64'd0);

        // Late inst_valid in REQ is dropped.
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        step();
        check("late_iv_valid", 64'(if_req_valid), 64'd1);
        check("late_iv_addr", 64'(if_req_addr), 64'h8000_0000);

        // PC wrap-around.
        run_instr(1'b1, 1'b1, 32'h4, 32'hFFFF_FFF8, 1'b0);
        check("pre_wrap_pc", 64'(pc), 64'hFFFF_FFFC);
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("wrap_pc", 64'(pc), 64'h0000_0000);
        check("wrap_cnt", retire_cnt, 64'd2);

        // Retire counter wrap.
        force dut.r_retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        step();
        check("cnt_preload", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("cnt_wrap", retire_cnt, 64'd0);
        check("cnt_wrap_pc", 64'(pc), 64'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
